// File: rtl/sti_cmd_scheduler.sv
// rtl/sti_cmd_scheduler.sv - round-robin command scheduler feeding the STI/DAC serializer
module sti_cmd_scheduler #(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [20:0] req0_cmd,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [20:0] req1_cmd,
    output logic        req1_ready,
    input  logic        end_req,
    output logic        load,
    output logic [15:0] pi_data,
    output logic [1:0]  pi_length,
    output logic        pi_fill,
    output logic        pi_msb,
    output logic        pi_low,
    output logic        pi_end,
    input  logic        so_valid,
    input  logic        pixel_finish,
    output logic        src_id,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int IW = $clog2(TIMEOUT + 1);

    // FIFO entry layout: {cmd[20:0], src}
    logic [21:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          r_rr;
    logic          r_end_pending;
    logic          r_done;
    logic          r_err;

    logic [2:0]    r_state;
    logic [15:0]   r_pi_data;
    logic [1:0]    r_pi_length;
    logic          r_pi_fill;
    logic          r_pi_msb;
    logic          r_pi_low;
    logic          r_src_id;
    logic [5:0]    r_expected;
    logic [5:0]    r_bitcnt;
    logic [IW-1:0] r_idle_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_push0;
    logic          w_push1;
    logic          w_push;
    logic          w_pop;
    logic [21:0]   w_push_entry;
    logic [21:0]   w_head;
    logic [5:0]    w_bit_next;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = !w_full && !r_end_pending && !r_done;

    // A lone requester always wins; on contention the rr pointer decides.
    assign w_grant0   = req0_valid && (!req1_valid || !r_rr);
    assign w_grant1   = req1_valid && (!req0_valid ||  r_rr);
    assign req0_ready = w_push_ok && w_grant0;
    assign req1_ready = w_push_ok && w_grant1;

    assign w_push0      = req0_valid && req0_ready;
    assign w_push1      = req1_valid && req1_ready;
    assign w_push       = w_push0 || w_push1;
    assign w_push_entry = w_push1 ? {req1_cmd, 1'b1} : {req0_cmd, 1'b0};
    assign w_pop        = (r_state == S_ISSUE);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_bit_next   = r_bitcnt + {5'd0, so_valid};

    assign load      = (r_state == S_ISSUE);
    assign pi_end    = (r_state == S_END);
    assign pi_data   = r_pi_data;
    assign pi_length = r_pi_length;
    assign pi_fill   = r_pi_fill;
    assign pi_msb    = r_pi_msb;
    assign pi_low    = r_pi_low;
    assign src_id    = r_src_id;
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign done      = r_done;
    assign err       = r_err;

    // Entry storage; reads are gated by the count so contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    // Round-robin pointer moves to the loser of each accepted push; end request is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr          <= 1'b0;
            r_end_pending <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr <= w_push0;
            end
            if (end_req) begin
                r_end_pending <= 1'b1;
            end
        end
    end

    // Issue FSM: pi_* are captured on entry to ISSUE so they are valid with the load strobe
    // and remain untouched until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pi_data   <= '0;
            r_pi_length <= '0;
            r_pi_fill   <= 1'b0;
            r_pi_msb    <= 1'b0;
            r_pi_low    <= 1'b0;
            r_src_id    <= 1'b0;
            r_expected  <= '0;
            r_bitcnt    <= '0;
            r_idle_cnt  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_pi_data   <= w_head[21:6];
                        r_pi_length <= w_head[5:4];
                        r_pi_fill   <= w_head[3];
                        r_pi_msb    <= w_head[2];
                        r_pi_low    <= w_head[1];
                        r_src_id    <= w_head[0];
                        r_state     <= S_ISSUE;
                    end else if (r_end_pending) begin
                        r_state <= S_END;
                    end
                end
                S_ISSUE: begin
                    r_expected <= {({1'b0, r_pi_length} + 3'd1), 3'b000};
                    r_bitcnt   <= '0;
                    r_idle_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (so_valid) begin
                        r_bitcnt   <= w_bit_next;
                        r_idle_cnt <= '0;
                        if (w_bit_next == r_expected) begin
                            r_state <= S_GAP;
                        end
                    end else if (r_idle_cnt == IW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IW'(1);
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                S_END: begin
                    if (pixel_finish) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sti_cmd_scheduler.sv
// tb/tb_sti_cmd_scheduler.sv - directed scoreboard bench for sti_cmd_scheduler
module tb_sti_cmd_scheduler;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [20:0] req0_cmd;
    logic        req0_ready;
    logic        req1_valid;
    logic [20:0] req1_cmd;
    logic        req1_ready;
    logic        end_req;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        so_valid;
    logic        pixel_finish;
    logic        src_id;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_loads = 0;
    int cyc     = 0;

    logic [21:0] sb[$];
    logic [21:0] cur;
    logic [21:0] obs;
    bit          have_cur;
    bit          m_rr;
    bit          m_end;
    bit          m_done;
    bit          e0;
    bit          e1;
    bit          pok;

    sti_cmd_scheduler #(.DEPTH(DEPTH), .AW(2), .TIMEOUT(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_cmd     (req0_cmd),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_cmd     (req1_cmd),
        .req1_ready   (req1_ready),
        .end_req      (end_req),
        .load         (load),
        .pi_data      (pi_data),
        .pi_length    (pi_length),
        .pi_fill      (pi_fill),
        .pi_msb       (pi_msb),
        .pi_low       (pi_low),
        .pi_end       (pi_end),
        .so_valid     (so_valid),
        .pixel_finish (pixel_finish),
        .src_id       (src_id),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Monitor: ready model, scoreboard push on handshake, pop and compare on load.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                m_rr = 0; m_end = 0; m_done = 0; have_cur = 0;
            end else begin
                if (req0_valid || req1_valid) begin
                    pok = (sb.size() < DEPTH) && !m_end && !m_done;
                    e0  = pok && req0_valid && (!req1_valid || !m_rr);
                    e1  = pok && req1_valid && (!req0_valid || m_rr);
                    chk("ready_model", 64'({req0_ready, req1_ready}), 64'({e0, e1}));
                end
                obs = {pi_data, pi_length, pi_fill, pi_msb, pi_low, src_id};
                if (load) begin
                    n_loads++;
                    chk("queue_nonempty_on_load", 64'(sb.size() > 0), 64'(1));
                    if (sb.size() > 0) begin
                        cur = sb.pop_front();
                        chk("issue_entry", 64'(obs), 64'(cur));
                        have_cur = 1;
                    end
                end else if (have_cur) begin
                    chk("pi_hold", 64'(obs), 64'(cur));
                end
                if (req0_valid && req0_ready) begin
                    sb.push_back({req0_cmd, 1'b0});
                    m_rr = 1;
                    chk("fifo_bound", 64'(sb.size() <= DEPTH), 64'(1));
                end else if (req1_valid && req1_ready) begin
                    sb.push_back({req1_cmd, 1'b1});
                    m_rr = 0;
                    chk("fifo_bound", 64'(sb.size() <= DEPTH), 64'(1));
                end
                if (end_req) m_end = 1;
                if (pi_end && pixel_finish) m_done = 1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push(input int src, input logic [20:0] cmd, input bit with_end, output int ac);
        bit ok;
        ok = 0;
        ac = 0;
        if (src == 0) begin req0_cmd = cmd; req0_valid = 1'b1; end
        else          begin req1_cmd = cmd; req1_valid = 1'b1; end
        end_req = with_end;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((src == 0) ? req0_ready : req1_ready) begin
                ok = 1;
                ac = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        chk("push_accept", 64'(ok), 64'(1));
        if (ok) begin @(posedge clk); #1; end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        end_req    = 1'b0;
    endtask

    task automatic wait_load(output int lc);
        bit found;
        found = 0;
        lc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (load) begin
                found = 1;
                lc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        chk("load_seen", 64'(found), 64'(1));
        if (found) begin @(posedge clk); #1; end
    endtask

    task automatic serve(input int n, output int last);
        so_valid = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        so_valid = 1'b0;
        last = cyc - 1;
    endtask

    task automatic check_exit_idle(input string tag);
        @(negedge clk);
        chk({tag, "_gap_busy"}, 64'(busy), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
        chk({tag, "_idle_load"}, 64'(load), 64'(0));
        @(posedge clk); #1;
    endtask

    logic [20:0] c0 [4];
    logic [20:0] c1 [4];
    logic [20:0] cx;
    logic [20:0] cy;
    logic [31:0] rnd;
    int ac, ac2, lc, lc2, last, i0, i1, prev, loads0;

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_cmd = '0; req1_valid = 0; req1_cmd = '0;
        end_req = 0; so_valid = 0; pixel_finish = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_load", 64'(load), 64'(0));
        chk("rst_pi", 64'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 64'(0));
        chk("rst_pi_end", 64'(pi_end), 64'(0));
        chk("rst_src", 64'(src_id), 64'(0));
        chk("rst_flags", 64'({busy, done, err}), 64'(0));
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Single command, length 01 -> 16 bits, latency 2
        cx = {16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0};
        push(0, cx, 0, ac);
        wait_load(lc);
        chk("t1_latency", 64'(lc - ac), 64'(2));
        chk("t1_src", 64'(src_id), 64'(0));
        serve(16, last);
        chk("t1_len_held", 64'(pi_length), 64'(2'b01));
        check_exit_idle("t1");

        // Both requesters valid continuously, 4 commands each
        for (int k = 0; k < 4; k++) begin
            rnd = $urandom; c0[k] = {rnd[15:0], 2'b00, rnd[18:16]};
            rnd = $urandom; c1[k] = {rnd[15:0], 2'b00, rnd[18:16]};
        end
        i0 = 0; i1 = 0; prev = 2;
        so_valid = 1'b1;
        req0_cmd = c0[0]; req0_valid = 1'b1;
        req1_cmd = c1[0]; req1_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin
                chk("t2_alternate", 64'(prev != 0), 64'(1));
                prev = 0; i0++;
            end else if (req1_valid && req1_ready) begin
                chk("t2_alternate", 64'(prev != 1), 64'(1));
                prev = 1; i1++;
            end
            @(posedge clk); #1;
            req0_valid = (i0 < 4);
            req1_valid = (i1 < 4);
            if (i0 < 4) req0_cmd = c0[i0];
            if (i1 < 4) req1_cmd = c1[i1];
            if (i0 == 4 && i1 == 4) break;
        end
        chk("t2_accepted", 64'(i0 + i1), 64'(8));
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("t2_drained", 64'(busy), 64'(0));
        @(posedge clk); #1;
        so_valid = 1'b0;
        chk("t2_sb_empty", 64'(sb.size()), 64'(0));

        // length 00 then 11 back-to-back
        cx = {16'h1234, 2'b00, 1'b1, 1'b0, 1'b1};
        cy = {16'hBEEF, 2'b11, 1'b0, 1'b1, 1'b1};
        push(0, cx, 0, ac);
        push(0, cy, 0, ac2);
        wait_load(lc);
        serve(8, last);
        wait_load(lc2);
        chk("t3_len00_exit", 64'(lc2 - last), 64'(3));
        serve(32, last);
        check_exit_idle("t3_len11");

        // WAIT timeout, then the next queued command still issues
        cx = {16'h0F0F, 2'b00, 1'b0, 1'b0, 1'b0};
        cy = {16'hF00D, 2'b00, 1'b1, 1'b1, 1'b0};
        push(0, cx, 0, ac);
        push(1, cy, 0, ac2);
        wait_load(lc);
        repeat (63) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_err_before", 64'(err), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_err_set", 64'(err), 64'(1));
        chk("t5_idle_load", 64'(load), 64'(0));
        @(posedge clk); #1;
        wait_load(lc2);
        chk("t5_next_issue", 64'(lc2 - lc), 64'(66));
        serve(8, last);
        check_exit_idle("t5");
        chk("t5_err_sticky", 64'(err), 64'(1));

        // Reset during WAIT with two entries queued
        rnd = $urandom;
        push(0, {rnd[15:0], 5'b00000}, 0, ac);
        push(1, {rnd[31:16], 5'b00101}, 0, ac);
        push(0, {rnd[23:8], 5'b00010}, 0, ac);
        serve(3, last);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_load", 64'(load), 64'(0));
        chk("t6_pi", 64'({pi_data, pi_length, pi_fill, pi_msb, pi_low, src_id}), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_err", 64'(err), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        loads0 = n_loads;
        so_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        so_valid = 1'b0;
        chk("t6_no_loads", 64'(n_loads - loads0), 64'(0));

        // end_req with 3 commands queued; last push shares the cycle with end_req
        loads0 = n_loads;
        push(0, {16'h1111, 5'b00001}, 0, ac);
        push(1, {16'h2222, 5'b00010}, 0, ac);
        push(0, {16'h3333, 5'b00100}, 1, ac);
        req1_valid = 1'b1; req1_cmd = 21'h1ABCD;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t4_ready_after_end", 64'(req1_ready), 64'(0));
            @(posedge clk); #1;
        end
        req1_valid = 1'b0;
        serve(8, last);
        for (int k = 0; k < 2; k++) begin
            wait_load(lc);
            chk("t4_no_early_end", 64'(pi_end), 64'(0));
            serve(8, last);
        end
        chk("t4_three_issued", 64'(n_loads - loads0), 64'(3));
        @(negedge clk);
        chk("t4_gap_pi_end", 64'(pi_end), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_idle_pi_end", 64'(pi_end), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_end_pi_end", 64'(pi_end), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_end_held", 64'(pi_end), 64'(1));
        chk("t4_not_done", 64'(done), 64'(0));
        @(posedge clk); #1;
        pixel_finish = 1'b1;
        @(posedge clk); #1;
        pixel_finish = 1'b0;
        @(negedge clk);
        chk("t4_done", 64'(done), 64'(1));
        chk("t4_pi_end_low", 64'(pi_end), 64'(0));
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1; so_valid = 1'b1; pixel_finish = 1'b1;
        @(negedge clk);
        chk("t4_done_ready", 64'({req0_ready, req1_ready}), 64'(0));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; so_valid = 1'b0; pixel_finish = 1'b0;
        @(negedge clk);
        chk("t4_done_sticky", 64'({done, load, pi_end}), 64'(3'b100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
